square_sum_root: RTL and testbench

Inverse of the square accumulator: given an 8-bit target S, finds the largest N with 1²+2²+…+N² ≤ S, and flags whether the sum equals S exactly. It sits on the consumer side of the square-accumulator interface and reconstructs N from a sum. It uses the same datapath/controlpath split. Squares are built by repeated addition, and there is no multiplier.

---
 rtl/square_sum_root.sv | 226 ++++++++++++++++++++++
 tb/tb_square_sum_root.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/square_sum_root.sv
// Finds the largest N with 1^2+...+N^2 <= S by accumulating squares through repeated
// addition, and flags an exact hit. Split into a controller FSM and a datapath.

module square_sum_root_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic i_s_valid,
    input  logic i_j_eq_i,
    input  logic i_acc_gt,
    input  logic i_acc_eq,
    output logic o_load,
    output logic o_accum,
    output logic o_inc_j,
    output logic o_advance,
    output logic o_res_gt,
    output logic o_res_eq,
    output logic o_n_valid,
    output logic o_busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_n_valid;
    logic       r_busy;

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        o_load      = 1'b0;
        o_accum     = 1'b0;
        o_inc_j     = 1'b0;
        o_advance   = 1'b0;
        o_res_gt    = 1'b0;
        o_res_eq    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_s_valid) begin
                    o_load      = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                o_accum = 1'b1;
                if (i_j_eq_i) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    o_inc_j     = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_CHECK: begin
                if (i_acc_gt) begin
                    o_res_gt    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (i_acc_eq) begin
                    o_res_eq    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    o_advance   = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; strobes are registered from the next-state so they align with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_n_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_n_valid <= (w_state_nxt == ST_DONE);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_n_valid = r_n_valid;
    assign o_busy    = r_busy;
endmodule

module square_sum_root_dp (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_s,
    input  logic       i_load,
    input  logic       i_accum,
    input  logic       i_inc_j,
    input  logic       i_advance,
    input  logic       i_res_gt,
    input  logic       i_res_eq,
    output logic       o_j_eq_i,
    output logic       o_acc_gt,
    output logic       o_acc_eq,
    output logic [3:0] o_n,
    output logic       o_exact
);
    logic [7:0] r_target;
    logic [3:0] r_i;
    logic [3:0] r_j;
    logic [8:0] r_acc;
    logic [3:0] r_n;
    logic       r_exact;
    logic [8:0] w_target_ext;

    // acc is 9 bits: the final iteration (i=9) reaches 285, beyond any 8-bit target
    assign w_target_ext = {1'b0, r_target};
    assign o_j_eq_i     = (r_j == r_i);
    assign o_acc_gt     = (r_acc > w_target_ext);
    assign o_acc_eq     = (r_acc == w_target_ext);

    // Working registers: square of i built as i added i times
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= 8'd0;
            r_i      <= 4'd0;
            r_j      <= 4'd0;
            r_acc    <= 9'd0;
        end else if (i_load) begin
            r_target <= i_s;
            r_i      <= 4'd1;
            r_j      <= 4'd1;
            r_acc    <= 9'd0;
        end else if (i_accum) begin
            r_acc <= r_acc + {5'd0, r_i};
            if (i_inc_j) begin
                r_j <= r_j + 4'd1;
            end else begin
                r_j <= r_j;
            end
        end else if (i_advance) begin
            r_i <= r_i + 4'd1;
            r_j <= 4'd1;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result registers hold from one DONE to the next; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n     <= 4'd0;
            r_exact <= 1'b0;
        end else if (i_res_gt) begin
            r_n     <= r_i - 4'd1;
            r_exact <= 1'b0;
        end else if (i_res_eq) begin
            r_n     <= r_i;
            r_exact <= 1'b1;
        end else begin
            r_n     <= r_n;
            r_exact <= r_exact;
        end
    end

    assign o_n     = r_n;
    assign o_exact = r_exact;
endmodule

module square_sum_root (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] S,
    input  logic       S_valid,
    output logic [3:0] N,
    output logic       exact,
    output logic       N_valid,
    output logic       busy
);
    logic w_load;
    logic w_accum;
    logic w_inc_j;
    logic w_advance;
    logic w_res_gt;
    logic w_res_eq;
    logic w_j_eq_i;
    logic w_acc_gt;
    logic w_acc_eq;

    square_sum_root_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .i_s_valid (S_valid),
        .i_j_eq_i  (w_j_eq_i),
        .i_acc_gt  (w_acc_gt),
        .i_acc_eq  (w_acc_eq),
        .o_load    (w_load),
        .o_accum   (w_accum),
        .o_inc_j   (w_inc_j),
        .o_advance (w_advance),
        .o_res_gt  (w_res_gt),
        .o_res_eq  (w_res_eq),
        .o_n_valid (N_valid),
        .o_busy    (busy)
    );

    square_sum_root_dp u_dp (
        .clk       (clk),
        .reset     (reset),
        .i_s       (S),
        .i_load    (w_load),
        .i_accum   (w_accum),
        .i_inc_j   (w_inc_j),
        .i_advance (w_advance),
        .i_res_gt  (w_res_gt),
        .i_res_eq  (w_res_eq),
        .o_j_eq_i  (w_j_eq_i),
        .o_acc_gt  (w_acc_gt),
        .o_acc_eq  (w_acc_eq),
        .o_n       (N),
        .o_exact   (exact)
    );
endmodule

// File: tb/tb_square_sum_root.sv
// Self-checking bench for square_sum_root: directed cases, full sweep and random
// targets checked against an arithmetic model of the sum-of-squares search.

module tb_square_sum_root;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] S;
    logic       S_valid;
    logic [3:0] N;
    logic       exact;
    logic       N_valid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    square_sum_root dut (
        .clk     (clk),
        .reset   (reset),
        .S       (S),
        .S_valid (S_valid),
        .N       (N),
        .exact   (exact),
        .N_valid (N_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sq_sum(input int n);
        return n * (n + 1) * (2 * n + 1) / 6;
    endfunction

    function automatic int ref_n(input int s);
        int n = 0;
        while (sq_sum(n + 1) <= s) n++;
        return n;
    endfunction

    // The search starts at i=1, so the empty sum never counts as an exact hit
    function automatic int ref_exact(input int s);
        int n = ref_n(s);
        return (n > 0 && sq_sum(n) == s) ? 1 : 0;
    endfunction

    function automatic int ref_k(input int s);
        return ref_exact(s) ? ref_n(s) : ref_n(s) + 1;
    endfunction

    function automatic int ref_lat(input int s);
        int k = ref_k(s);
        return 1 + k * (k + 1) / 2 + k;
    endfunction

    // Issue one request now (we are in an IDLE cycle, #1 after an edge) and check its result.
    // pulse_cyc > 0 injects a stray S_valid with S=1 in that cycle of the run.
    task automatic run_req(input int s, input int pulse_cyc);
        int cyc;
        int max_acc;
        bit busy_ok;
        bit seen;
        S       = s[7:0];
        S_valid = 1'b1;
        @(posedge clk); #1;
        S_valid = 1'b0;
        S       = 8'($urandom);
        cyc     = 1;
        max_acc = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (cyc <= 100) begin
            if (int'(dut.u_dp.r_acc) > max_acc) max_acc = int'(dut.u_dp.r_acc);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (N_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            S_valid = (cyc == pulse_cyc) ? 1'b1 : 1'b0;
            S       = (cyc == pulse_cyc) ? 8'd1 : 8'($urandom);
        end
        S_valid = 1'b0;
        check($sformatf("S=%0d latency", s), seen ? cyc : 0, ref_lat(s));
        check($sformatf("S=%0d N", s), {28'd0, N}, ref_n(s));
        check($sformatf("S=%0d exact", s), {31'd0, exact}, ref_exact(s));
        check($sformatf("S=%0d busy_during_run", s), {31'd0, busy_ok}, 1);
        check($sformatf("S=%0d acc_peak", s), max_acc, sq_sum(ref_k(s)));
        @(posedge clk); #1;
        check($sformatf("S=%0d N_valid_one_cycle", s), {31'd0, N_valid}, 0);
        check($sformatf("S=%0d busy_after_done", s), {31'd0, busy}, 0);
        check($sformatf("S=%0d N_held", s), {28'd0, N}, ref_n(s));
    endtask

    initial begin
        int cnt;
        int cyc;
        reset   = 1'b1;
        S       = 8'd0;
        S_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset N", {28'd0, N}, 0);
        check("reset exact", {31'd0, exact}, 0);
        check("reset N_valid", {31'd0, N_valid}, 0);
        check("reset busy", {31'd0, busy}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the boundaries of the search
        run_req(0, 0);
        run_req(5, 0);
        run_req(13, 0);
        run_req(255, 0);
        run_req(204, 0);

        // Stray request during ACCUM of iteration 3 must be dropped
        run_req(140, 6);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (N_valid === 1'b1) cnt++;
        end
        check("dropped request extra N_valid", cnt, 0);
        check("dropped request N kept", {28'd0, N}, 7);

        // Reset mid-computation abandons the run
        S       = 8'd255;
        S_valid = 1'b1;
        @(posedge clk); #1;
        S_valid = 1'b0;
        cyc     = 1;
        cnt     = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (N_valid === 1'b1) cnt++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset N_valid", {31'd0, N_valid}, 0);
        check("midreset N", {28'd0, N}, 0);
        check("midreset exact", {31'd0, exact}, 0);
        check("midreset busy", {31'd0, busy}, 0);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (N_valid === 1'b1) cnt++;
        end
        check("midreset no N_valid", cnt, 0);
        run_req(30, 0);

        // Full sweep, back to back
        for (int s = 0; s < 256; s++) run_req(s, 0);

        // Random targets
        for (int r = 0; r < 40; r++) run_req(int'($urandom_range(255, 0)), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
